// File: rtl/usb_rx_data_buffer.sv
// rtl/usb_rx_data_buffer.sv - packet-committing receive byte buffer between usb_rx and the AHB slave
module usb_rx_data_buffer #(
   parameter int DEPTH = 64,
   parameter int PTR_W = 7
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [2:0]       rx_packet,
   input  logic [7:0]       rx_packet_data,
   input  logic             store_rx_packet_data,
   input  logic             get_rx_data,
   input  logic             flush,
   input  logic             clear_overflow,
   output logic [7:0]       rx_data,
   output logic [PTR_W-1:0] buffer_occupancy,
   output logic             rx_data_ready,
   output logic             rx_done,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] PKT_DONE  = 3'b101;
   localparam logic [2:0] PKT_ERROR = 3'b100;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] cptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] total;
   logic [PTR_W-1:0] wptr_next;
   logic [2:0]       prev_pkt;
   logic             pkt_bad;
   logic             full;
   logic             store_ok;
   logic             drop;
   logic             read_ok;
   logic             done_entry;
   logic             err_entry;

   // Pointer arithmetic, full/drop decisions and packet-code entry detection
   always_comb begin
      total            = wptr - rptr;
      buffer_occupancy = cptr - rptr;
      full             = (total == PTR_W'(DEPTH));
      store_ok         = store_rx_packet_data && !full;
      drop             = store_rx_packet_data && full;
      read_ok          = get_rx_data && (buffer_occupancy != '0);
      wptr_next        = wptr + PTR_W'(store_ok);
      done_entry       = (rx_packet == PKT_DONE) && (prev_pkt != PKT_DONE);
      err_entry        = (rx_packet == PKT_ERROR) && (prev_pkt != PKT_ERROR);
      rx_data_ready    = (buffer_occupancy != '0);
      rx_data          = rx_data_ready ? mem[rptr[AW-1:0]] : 8'h00;
   end

   // Byte storage; a byte written past the commit point is simply orphaned on rollback
   always_ff @(posedge clk) begin
      if (store_ok)
         mem[wptr[AW-1:0]] <= rx_packet_data;
   end

   // Pointer, packet-status and flag updates: flush > error rollback > done > store/read
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr     <= '0;
         cptr     <= '0;
         rptr     <= '0;
         prev_pkt <= 3'b000;
         pkt_bad  <= 1'b0;
         rx_done  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         prev_pkt <= rx_packet;
         rx_done  <= 1'b0;
         if (drop && !flush)
            overflow <= 1'b1;
         else if (clear_overflow)
            overflow <= 1'b0;
         if (flush) begin
            wptr    <= '0;
            cptr    <= '0;
            rptr    <= '0;
            pkt_bad <= 1'b0;
         end else begin
            if (read_ok)
               rptr <= rptr + PTR_W'(1);
            if (err_entry) begin
               wptr    <= cptr;
               pkt_bad <= 1'b0;
            end else if (done_entry) begin
               // A byte dropped in the DONE cycle itself also spoils the packet
               if (pkt_bad || drop) begin
                  wptr    <= cptr;
                  pkt_bad <= 1'b0;
               end else begin
                  wptr    <= wptr_next;
                  cptr    <= wptr_next;
                  rx_done <= 1'b1;
               end
            end else begin
               wptr <= wptr_next;
               if (drop)
                  pkt_bad <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// tb/tb_usb_rx_data_buffer.sv - directed scoreboard bench for usb_rx_data_buffer
module tb_usb_rx_data_buffer;

   logic       tb_clk;
   logic       n_rst;
   logic [2:0] rx_packet;
   logic [7:0] rx_packet_data;
   logic       store_rx_packet_data;
   logic       get_rx_data;
   logic       flush;
   logic       clear_overflow;
   logic [7:0] rx_data;
   logic [6:0] buffer_occupancy;
   logic       rx_data_ready;
   logic       rx_done;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] pend_q[$];
   bit         m_bad = 0;
   bit         m_ovf = 0;
   logic [2:0] m_prev = 3'b000;
   int         done_cnt;

   usb_rx_data_buffer dut (
      .clk                  (tb_clk),
      .n_rst                (n_rst),
      .rx_packet            (rx_packet),
      .rx_packet_data       (rx_packet_data),
      .store_rx_packet_data (store_rx_packet_data),
      .get_rx_data          (get_rx_data),
      .flush                (flush),
      .clear_overflow       (clear_overflow),
      .rx_data              (rx_data),
      .buffer_occupancy     (buffer_occupancy),
      .rx_data_ready        (rx_data_ready),
      .rx_done              (rx_done),
      .overflow             (overflow)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, model the edge, compare at the following negedge
   task automatic cyc(input bit st, input logic [7:0] d, input bit rd,
                      input logic [2:0] pkt, input bit fl, input bit co);
      bit done_e, err_e, drop, rd_ok, exp_done;
      done_e = (pkt == 3'b101) && (m_prev != 3'b101);
      err_e  = (pkt == 3'b100) && (m_prev != 3'b100);
      drop   = st && ((exp_q.size() + pend_q.size()) == 64);
      rd_ok  = rd && (exp_q.size() != 0);
      rx_packet            = pkt;
      rx_packet_data       = d;
      store_rx_packet_data = st;
      get_rx_data          = rd;
      flush                = fl;
      clear_overflow       = co;
      @(negedge tb_clk);
      store_rx_packet_data = 1'b0;
      get_rx_data          = 1'b0;
      flush                = 1'b0;
      clear_overflow       = 1'b0;
      m_prev   = pkt;
      exp_done = 0;
      if (co) m_ovf = 0;
      if (drop && !fl) m_ovf = 1;
      if (fl) begin
         exp_q.delete();
         pend_q.delete();
         m_bad = 0;
      end else begin
         if (rd_ok) void'(exp_q.pop_front());
         if (err_e) begin
            pend_q.delete();
            m_bad = 0;
         end else if (done_e) begin
            if (m_bad || drop) begin
               pend_q.delete();
               m_bad = 0;
            end else begin
               if (st) pend_q.push_back(d);
               foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
               pend_q.delete();
               exp_done = 1;
            end
         end else begin
            if (st && !drop) pend_q.push_back(d);
            if (drop) m_bad = 1;
         end
      end
      if (rx_done) done_cnt++;
      chk("rx_done", 32'(rx_done), 32'(exp_done));
      chk("occupancy", 32'(buffer_occupancy), 32'(exp_q.size()));
      chk("ready", 32'(rx_data_ready), 32'(exp_q.size() != 0));
      chk("rx_data", 32'(rx_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic store_n(input int n);
      for (int i = 0; i < n; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 3'b010, 0, 0);
   endtask

   task automatic done_pkt();
      cyc(0, 8'h00, 0, 3'b101, 0, 0);
      cyc(0, 8'h00, 0, 3'b000, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 70 && exp_q.size() != 0; i++) cyc(0, 8'h00, 1, 3'b000, 0, 0);
   endtask

   initial begin
      n_rst = 1'b0;
      rx_packet = 3'b000;
      rx_packet_data = 8'h00;
      store_rx_packet_data = 1'b0;
      get_rx_data = 1'b0;
      flush = 1'b0;
      clear_overflow = 1'b0;
      repeat (2) @(negedge tb_clk);
      chk("rst_occ", 32'(buffer_occupancy), 32'h0);
      chk("rst_data", 32'(rx_data), 32'h0);
      chk("rst_ready", 32'(rx_data_ready), 32'h0);
      chk("rst_done", 32'(rx_done), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      n_rst = 1'b1;
      @(negedge tb_clk);

      // Basic packet: two bytes, commit, read out, extra read while empty
      cyc(1, 8'hA5, 0, 3'b010, 0, 0);
      cyc(1, 8'h3C, 0, 3'b010, 0, 0);
      cyc(0, 8'h00, 0, 3'b101, 0, 0);
      chk("first_byte", 32'(rx_data), 32'hA5);
      cyc(0, 8'h00, 0, 3'b000, 0, 0);
      cyc(0, 8'h00, 1, 3'b000, 0, 0);
      chk("second_byte", 32'(rx_data), 32'h3C);
      cyc(0, 8'h00, 1, 3'b000, 0, 0);
      cyc(0, 8'h00, 1, 3'b000, 0, 0);

      // ERROR rollback keeps only the committed bytes
      store_n(2);
      done_pkt();
      store_n(3);
      cyc(0, 8'h00, 0, 3'b100, 0, 0);
      cyc(0, 8'h00, 0, 3'b010, 0, 0);
      store_n(1);
      done_pkt();
      drain();

      // Fill to 64, overflow spoils the next packet, flush keeps overflow, then clear
      store_n(64);
      done_pkt();
      cyc(1, 8'h77, 0, 3'b010, 0, 0);
      done_pkt();
      cyc(0, 8'h00, 0, 3'b000, 1, 0);
      cyc(0, 8'h00, 0, 3'b000, 0, 1);

      // Three 40-byte packets with interleaved reads cross the pointer wrap
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 40; i++) begin
            cyc(1, 8'($urandom_range(0, 255)), 0, 3'b010, 0, 0);
            if (exp_q.size() != 0) cyc(0, 8'h00, 1, 3'b010, 0, 0);
         end
         done_pkt();
      end
      drain();

      // DONE held for 10 cycles yields one pulse
      store_n(1);
      done_cnt = 0;
      repeat (10) cyc(0, 8'h00, 0, 3'b101, 0, 0);
      chk("held_done_cnt", 32'(done_cnt), 32'd1);
      cyc(0, 8'h00, 0, 3'b000, 0, 0);
      store_n(4);
      done_pkt();
      store_n(3);
      done_pkt();
      cyc(0, 8'h00, 1, 3'b010, 0, 0);
      cyc(0, 8'h00, 1, 3'b010, 0, 0);
      cyc(0, 8'h00, 1, 3'b010, 0, 0);
      chk("occ_at_5", 32'(buffer_occupancy), 32'd5);
      // Store, read and commit in one cycle: occupancy holds at 5
      cyc(1, 8'h5E, 1, 3'b101, 0, 0);
      chk("occ_same_cycle", 32'(buffer_occupancy), 32'd5);
      cyc(0, 8'h00, 0, 3'b000, 0, 0);
      drain();

      // Flush with 4 committed and 2 pending, then an empty commit
      store_n(4);
      done_pkt();
      store_n(2);
      cyc(0, 8'h00, 0, 3'b010, 1, 0);
      chk("flush_ready", 32'(rx_data_ready), 32'h0);
      done_pkt();
      chk("flush_occ_after_done", 32'(buffer_occupancy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
